fmap_stream_reader: RTL and testbench

FMAP_STREAM_READER -- requirements
Module: fmap_stream_reader

---
 rtl/fmap_stream_reader.sv | 107 ++++++++++
 tb/tb_fmap_stream_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_stream_reader.sv
// Streams a 12x12x18 binary feature map out one pixel per beat in raster order,
// with valid/ready handshaking, abort, and a done pulse after the final beat.
module fmap_stream_reader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        fmap_in [0:12*12*18-1],
  input  logic        out_ready,
  output logic        out_valid,
  output logic [17:0] out_data,
  output logic [3:0]  out_row,
  output logic [3:0]  out_col,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CHANNELS = 18;
  localparam int unsigned PLANE    = 144;
  localparam logic [3:0]  MAX_IDX  = 4'd11;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic       done_q, done_d;

  logic       at_last;
  logic       accept;
  logic [7:0] pix_idx;

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign at_last   = (row_q == MAX_IDX) && (col_q == MAX_IDX);
  assign out_last  = out_valid && at_last;
  assign accept    = out_valid && out_ready;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign done      = done_q;

  // Offset of the current pixel within one channel plane.
  assign pix_idx = 8'(row_q) * 8'd12 + 8'(col_q);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_chan
      localparam logic [11:0] BASE = 12'(gi * PLANE);
      assign out_data[gi] = fmap_in[BASE + {4'd0, pix_idx}];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= 4'd0;
      col_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // start wins over abort here; abort has nothing to cancel in IDLE.
        if (start) begin
          state_d = STREAM;
          row_d   = 4'd0;
          col_d   = 4'd0;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          row_d   = 4'd0;
          col_d   = 4'd0;
        end else if (accept) begin
          if (at_last) begin
            state_d = IDLE;
            row_d   = 4'd0;
            col_d   = 4'd0;
            done_d  = 1'b1;
          end else if (col_q == MAX_IDX) begin
            col_d = 4'd0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed bench for fmap_stream_reader: table-driven beat checks on a full
// stream plus hand-written sequences for backpressure, start/abort and reset.
module tb_fmap_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic        fmap [0:2591];
  logic        out_valid;
  logic [17:0] out_data;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;
  int pat_sel  = 0;

  always #5 clk = ~clk;

  fmap_stream_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .fmap_in   (fmap),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int         beat;
    logic [3:0] row;
    logic [3:0] col;
    logic [17:0] data;
    logic       last;
  } vec_t;

  vec_t vecs [7];

  logic [3:0]  cap_row  [144];
  logic [3:0]  cap_col  [144];
  logic [17:0] cap_data [144];
  logic        cap_last [144];
  logic        cap_valid[144];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pattern 0: bit = (r+c+ch)&1 ; pattern 1: only ch17 of pixel (11,11) set.
  function automatic logic [17:0] exp_data(input int b);
    int r;
    int c;
    r = b / 12;
    c = b % 12;
    if (pat_sel == 0) return (((r + c) % 2) != 0) ? 18'h15555 : 18'h2AAAA;
    return (b == 143) ? 18'h20000 : 18'h00000;
  endfunction

  task automatic set_pattern(input int p);
    pat_sel = p;
    for (int i = 0; i < 2592; i++) begin
      if (p == 0) fmap[i] = (((i / 144) + ((i % 144) / 12) + (i % 12)) % 2) != 0;
      else        fmap[i] = (i == 17 * 144 + 143);
    end
  endtask

  task automatic expect_beat(input int b);
    chk($sformatf("beat%0d_valid", b), 32'(out_valid), 32'd1);
    chk($sformatf("beat%0d_row", b),   32'(out_row),   32'(b / 12));
    chk($sformatf("beat%0d_col", b),   32'(out_col),   32'(b % 12));
    chk($sformatf("beat%0d_data", b),  32'(out_data),  32'(exp_data(b)));
    chk($sformatf("beat%0d_last", b),  32'(out_last),  32'(b == 143));
  endtask

  task automatic expect_idle(input string tag, input logic exp_done);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'(exp_done));
    chk({tag, "_last"},  32'(out_last),  32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int done_cnt;
    int cyc;
    logic prev_stall;
    logic [3:0]  p_row;
    logic [3:0]  p_col;
    logic [17:0] p_data;
    logic        p_last;

    vecs[0] = '{0,   4'd0,  4'd0,  18'h2AAAA, 1'b0};
    vecs[1] = '{1,   4'd0,  4'd1,  18'h15555, 1'b0};
    vecs[2] = '{11,  4'd0,  4'd11, 18'h15555, 1'b0};
    vecs[3] = '{12,  4'd1,  4'd0,  18'h15555, 1'b0};
    vecs[4] = '{77,  4'd6,  4'd5,  18'h15555, 1'b0};
    vecs[5] = '{142, 4'd11, 4'd10, 18'h15555, 1'b0};
    vecs[6] = '{143, 4'd11, 4'd11, 18'h2AAAA, 1'b1};

    // Reset state
    set_pattern(0);
    #1;
    expect_idle("reset", 1'b0);
    chk("reset_row", 32'(out_row), 32'd0);
    chk("reset_col", 32'(out_col), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("post_reset", 1'b0);

    // Full stream at out_ready=1, captured then compared against the table
    out_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < 144; b++) begin
      cap_valid[b] = out_valid;
      cap_row[b]   = out_row;
      cap_col[b]   = out_col;
      cap_data[b]  = out_data;
      cap_last[b]  = out_last;
      @(negedge clk);
    end
    expect_idle("full_done_cycle", 1'b1);
    @(negedge clk);
    expect_idle("full_after_done", 1'b0);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("vec%0d_row", i),  32'(cap_row[vecs[i].beat]),  32'(vecs[i].row));
      chk($sformatf("vec%0d_col", i),  32'(cap_col[vecs[i].beat]),  32'(vecs[i].col));
      chk($sformatf("vec%0d_data", i), 32'(cap_data[vecs[i].beat]), 32'(vecs[i].data));
      chk($sformatf("vec%0d_last", i), 32'(cap_last[vecs[i].beat]), 32'(vecs[i].last));
    end
    for (int b = 0; b < 144; b++) begin
      chk($sformatf("full%0d_valid", b), 32'(cap_valid[b]), 32'd1);
      chk($sformatf("full%0d_rc", b), 32'({cap_row[b], cap_col[b]}),
          32'({4'(b / 12), 4'(b % 12)}));
      chk($sformatf("full%0d_last", b), 32'(cap_last[b]), 32'(b == 143));
    end

    // Backpressure with pseudo-random out_ready
    pulse_start();
    acc = 0; done_cnt = 0; cyc = 0; prev_stall = 1'b0;
    p_row = '0; p_col = '0; p_data = '0; p_last = 1'b0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (prev_stall) begin
        chk("bp_stall_valid", 32'(out_valid), 32'd1);
        chk("bp_stall_beat", 32'({out_row, out_col, out_data, out_last}),
            32'({p_row, p_col, p_data, p_last}));
      end
      if (done) done_cnt++;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        chk($sformatf("bp_acc%0d_rc", acc), 32'({out_row, out_col}),
            32'({4'(acc / 12), 4'(acc % 12)}));
        chk($sformatf("bp_acc%0d_data", acc), 32'(out_data), 32'(exp_data(acc)));
        chk($sformatf("bp_acc%0d_last", acc), 32'(out_last), 32'(acc == 143));
        acc++;
      end
      prev_stall = out_valid && !out_ready;
      p_row = out_row; p_col = out_col; p_data = out_data; p_last = out_last;
      cyc++;
      @(negedge clk);
    end
    chk("bp_accept_count", 32'(acc), 32'd144);
    chk("bp_done_count", 32'(done_cnt), 32'd1);
    expect_idle("bp_after_done", 1'b0);

    // Start ignored mid-stream and on the last accept; start in done cycle honoured
    out_ready = 1'b1;
    pulse_start();
    for (int b = 0; b < 144; b++) begin
      expect_beat(b);
      start = (b == 50) || (b == 143);
      @(negedge clk);
    end
    expect_idle("ign_done_cycle", 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_single_done", 32'(done), 32'd0);
    expect_beat(0);

    // Abort at (5,7)
    for (int b = 1; b <= 67; b++) begin
      @(negedge clk);
      expect_beat(b);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    expect_idle("abort_next", 1'b0);
    chk("abort_rc", 32'({out_row, out_col}), 32'd0);
    @(negedge clk);
    expect_idle("abort_after", 1'b0);

    // start and abort together in IDLE: start wins
    abort = 1'b1;
    pulse_start();
    abort = 1'b0;
    expect_beat(0);

    // abort coincident with last accept: no done
    for (int b = 1; b < 144; b++) begin
      @(negedge clk);
      expect_beat(b);
    end
    abort = 1'b1;
    @(negedge clk);
    expect_idle("abort_last", 1'b0);
    @(negedge clk);
    abort = 1'b0;
    expect_idle("abort_in_idle", 1'b0);

    // Asynchronous reset at beat 80
    pulse_start();
    for (int b = 0; b < 80; b++) begin
      @(negedge clk);
    end
    expect_beat(80);
    #2;
    rst_n = 1'b0;
    #1;
    expect_idle("async_rst", 1'b0);
    chk("async_rst_rc", 32'({out_row, out_col}), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_idle($sformatf("post_async%0d", k), 1'b0);
    end
    pulse_start();
    expect_beat(0);
    @(negedge clk);
    expect_beat(1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Single-channel map
    set_pattern(1);
    pulse_start();
    for (int b = 0; b < 144; b++) begin
      expect_beat(b);
      @(negedge clk);
    end
    expect_idle("single_done", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
